// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back sequencer:
// op classes, mux select encodings, FSM states and the write-cycle decoder.
package wb_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_RTYPE = 3'b001,
      OP_ITYPE = 3'b010,
      OP_LOAD  = 3'b011,
      OP_JAL   = 3'b100,
      OP_PUSH  = 3'b101,
      OP_POP   = 3'b110,
      OP_RSVD  = 3'b111
   } op_class_e;

   localparam logic [1:0] WR_RT = 2'b00;
   localparam logic [1:0] WR_RD = 2'b01;
   localparam logic [1:0] WR_RA = 2'b10;  // $31
   localparam logic [1:0] WR_SP = 2'b11;  // $29

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;
   localparam logic [1:0] WD_SP  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_MEM,
      S_WRITE1,
      S_WRITE2,
      S_FINISH
   } state_e;

   typedef struct packed {
      logic [1:0] wr_sel;
      logic [1:0] wd_sel;
      logic       sp_dir;
      logic       reg_write;
   } wb_ctl_t;

   // Mux selects and strobe for one write cycle; second selects POP's $29 update.
   // Writes aimed at rt/rd are suppressed when that register is $0.
   function automatic wb_ctl_t write_ctl(input op_class_e op, input logic second,
                                         input logic [4:0] rt, input logic [4:0] rd);
      wb_ctl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin c.wr_sel = WR_RD; c.wd_sel = WD_ALU; c.reg_write = (rd != 5'd0); end
         OP_ITYPE: begin c.wr_sel = WR_RT; c.wd_sel = WD_ALU; c.reg_write = (rt != 5'd0); end
         OP_LOAD:  begin c.wr_sel = WR_RT; c.wd_sel = WD_MEM; c.reg_write = (rt != 5'd0); end
         OP_JAL:   begin c.wr_sel = WR_RA; c.wd_sel = WD_PC;  c.reg_write = 1'b1; end
         OP_PUSH:  begin c.wr_sel = WR_SP; c.wd_sel = WD_SP;  c.sp_dir = 1'b0; c.reg_write = 1'b1; end
         OP_POP: begin
            if (second) begin
               c.wr_sel = WR_SP; c.wd_sel = WD_SP; c.sp_dir = 1'b1; c.reg_write = 1'b1;
            end else begin
               c.wr_sel = WR_RT; c.wd_sel = WD_MEM; c.reg_write = (rt != 5'd0);
            end
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/reg_write_ctrl.sv
// Register-file write-back sequencer: one or two write cycles per instruction,
// with a bounded wait for memory data on LOAD and POP.
module reg_write_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CW      = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op_class,
   input  logic [4:0] rt,
   input  logic [4:0] rd,
   input  logic       mem_ready,
   output logic [1:0] wr_sel,
   output logic [1:0] wd_sel,
   output logic       sp_dir,
   output logic       reg_write,
   output logic       busy,
   output logic       done,
   output logic       error
);
   import wb_ctrl_pkg::*;

   state_e        state, nxt;
   op_class_e     op_q, op_eff;
   logic [4:0]    rt_q, rd_q, rt_eff, rd_eff;
   logic [CW-1:0] cnt;
   logic          err_q, err_nxt;
   wb_ctl_t       ctl_nxt;

   // Outputs are decoded from the next state, so in IDLE the live inputs stand in
   // for the fields that are only captured on this same edge.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      op_eff  = (state == S_IDLE) ? op_class_e'(op_class) : op_q;
      rt_eff  = (state == S_IDLE) ? rt : rt_q;
      rd_eff  = (state == S_IDLE) ? rd : rd_q;
      nxt     = state;
      err_nxt = err_q;
      ctl_nxt = '0;

      case (state)
         S_IDLE: begin
            err_nxt = 1'b0;
            if (start) begin
               case (op_eff)
                  OP_LOAD, OP_POP: nxt = S_WAIT_MEM;
                  OP_NOP:          nxt = S_FINISH;
                  OP_RSVD: begin
                     nxt     = S_FINISH;
                     err_nxt = 1'b1;
                  end
                  default:         nxt = S_WRITE1;
               endcase
            end
         end
         S_WAIT_MEM: begin
            // Ready is checked first so data arriving on the last allowed cycle still wins.
            if (mem_ready) begin
               nxt = S_WRITE1;
            end else if (cnt == CW'(TIMEOUT)) begin
               nxt     = S_FINISH;
               err_nxt = 1'b1;
            end
         end
         S_WRITE1: nxt = (op_q == OP_POP) ? S_WRITE2 : S_FINISH;
         S_WRITE2: nxt = S_FINISH;
         S_FINISH: begin
            nxt     = S_IDLE;
            err_nxt = 1'b0;
         end
         default:  nxt = S_IDLE;
      endcase

      if (nxt == S_WRITE1)      ctl_nxt = write_ctl(op_eff, 1'b0, rt_eff, rd_eff);
      else if (nxt == S_WRITE2) ctl_nxt = write_ctl(op_eff, 1'b1, rt_eff, rd_eff);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: captured fields are reset too; they feed output decode and must never be X.
         state     <= S_IDLE;
         op_q      <= OP_NOP;
         rt_q      <= '0;
         rd_q      <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
         wr_sel    <= '0;
         wd_sel    <= '0;
         sp_dir    <= 1'b0;
         reg_write <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout so every register sees pre-edge values.
         state <= nxt;
         err_q <= err_nxt;
         if (state == S_IDLE && start) begin
            op_q <= op_eff;
            rt_q <= rt;
            rd_q <= rd;
         end
         // Held at zero outside WAIT_MEM, so it always enters that state cleared.
         cnt <= (state == S_WAIT_MEM) ? cnt + CW'(1) : '0;

         wr_sel    <= ctl_nxt.wr_sel;
         wd_sel    <= ctl_nxt.wd_sel;
         sp_dir    <= ctl_nxt.sp_dir;
         reg_write <= ctl_nxt.reg_write;
         busy      <= (nxt != S_IDLE);
         done      <= (nxt == S_FINISH);
         error     <= (nxt == S_FINISH) && err_nxt;
      end
   end

endmodule

// File: doc/reg_write_ctrl.md
# reg_write_ctrl

Register-file write-back sequencer for the multicycle datapath. It takes a decoded instruction class and drives the write-register select, write-data select and register-write strobe over one or two write cycles. Load and pop wait for memory data with a bounded wait. It sits between the main control FSM (start/done handshake) and the write-register mux, write-data mux and register bank.

## Interface

**Parameters**
- `TIMEOUT`, default 16: maximum cycles spent waiting for `mem_ready` before aborting. Legal range is ≥ 1.
- `CW`, default 5: width of the wait counter. Must satisfy 2^CW > TIMEOUT.

**Ports**
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request from the control FSM. Sampled only in IDLE.
- `op_class` input 3: instruction class, captured on an accepted start.
- `rt` input 5: rt field, captured on an accepted start.
- `rd` input 5: instruction bits 15:11, captured on an accepted start.
- `mem_ready` input 1: memory read data valid this cycle.
- `wr_sel` output 2: write-register mux select. 00 = rt, 01 = rd, 10 = $31, 11 = $29.
- `wd_sel` output 2: write-data mux select. 00 = ALU, 01 = MEM, 10 = PC, 11 = SP adjust.
- `sp_dir` output 1: SP adjuster direction. 0 = −4, 1 = +4.
- `reg_write` output 1: register-bank write strobe.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: one-cycle pulse, coincident with `done`, on timeout or reserved op.

## Operation

**op_class codes**
- 000 NOP: no write.
- 001 RTYPE: rd ← ALU.
- 010 ITYPE: rt ← ALU.
- 011 LOAD: wait for memory, then rt ← MEM.
- 100 JAL: $31 ← PC.
- 101 PUSH: $29 ← SP−4.
- 110 POP: wait for memory, then rt ← MEM, then $29 ← SP+4.
- 111: reserved.

**States:** IDLE, WAIT_MEM, WRITE1, WRITE2, FINISH.

**Transitions**
- IDLE, `start`=1:
  - LOAD or POP → WAIT_MEM.
  - RTYPE, ITYPE, JAL or PUSH → WRITE1.
  - NOP or reserved → FINISH. Reserved ops also set the error flag.
- WAIT_MEM:
  - `mem_ready`=1 → WRITE1.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT → FINISH with the error flag set, and no write is performed.
- WRITE1:
  - POP → WRITE2.
  - All other ops → FINISH.
- WRITE2 → FINISH.
- FINISH → IDLE. `done`=1, and `error`=flag.

**Output rules**
- All outputs are registered, Moore style, and decoded from the next state.
- `reg_write`=1 only in WRITE1 and WRITE2.
- `wr_sel`, `wd_sel` and `sp_dir` hold their value throughout WRITE1 and WRITE2 and are 0 elsewhere.

**$0 protection**
- If the resolved destination register is $0 (captured rt or rd equals 0 for an rt/rd-targeted write), `reg_write` stays 0 for that cycle.
- State timing is unchanged.
- POP with rt=0 still performs the $29 write.

**Other rules**
- `start` while busy is ignored. No queueing.
- Captured fields are stable from acceptance until IDLE. Input changes after acceptance have no effect.
- The wait counter clears on entry to WAIT_MEM.
- The error flag clears on return to IDLE.

## Timing

- Reset asserted: state IDLE, and all outputs are 0 (`wr_sel`, `wd_sel`, `sp_dir`, `reg_write`, `busy`, `done`, `error`), plus the counter and error flag. Takes effect immediately; no clock needed.
- Reset mid-sequence aborts with no further writes. The first active edge after release samples `start`.
- Single-write op accepted at edge N:
  - WRITE1 during cycle N+1.
  - `done` during cycle N+2.
  - Next accept possible at edge N+3.
- NOP or reserved op: `done` in cycle N+1.
- LOAD with `mem_ready` first high in WAIT_MEM cycle k (k=1 is cycle N+1):
  - WRITE1 in cycle N+k+1.
  - `done` in cycle N+k+2.
- POP adds one cycle: WRITE2 precedes FINISH.
- `mem_ready` high in the same cycle the counter hits TIMEOUT: ready wins, and the write proceeds.
- `busy` rises in cycle N+1 and falls in the cycle after `done`.

## Structure

- Shared package `wb_ctrl_pkg` holds:
  - op_class codes.
  - `wr_sel` constants (RT, RD, RA=31, SP=29).
  - `wd_sel` constants.
  - State enumeration.
- No sub-module. The wait counter is inline in the FSM process.

## Test plan

- RTYPE, rd=8: cycle N+1 has `reg_write`=1, `wr_sel`=01, `wd_sel`=00; cycle N+2 has `done`=1, `error`=0.
- LOAD, rt=9, `mem_ready` high on the 3rd WAIT_MEM cycle: WRITE1 at cycle N+4 with `wr_sel`=00, `wd_sel`=01; `done` at N+5.
- POP, rt=0, immediate `mem_ready`:
  - Cycle 2: `reg_write`=0, `wd_sel`=01.
  - Cycle 3: `reg_write`=1, `wr_sel`=11, `wd_sel`=11, `sp_dir`=1.
  - Cycle 4: `done`=1.
- JAL, then PUSH issued back-to-back:
  - JAL: `wr_sel`=10, `wd_sel`=10.
  - PUSH: `wr_sel`=11, `sp_dir`=0.
  - `start` asserted during JAL's busy period is ignored.
- LOAD with TIMEOUT=4 and `mem_ready` never high: no `reg_write` occurs; `done`=1 and `error`=1 arrive together 6 cycles after acceptance.
- Reset pulsed low during WAIT_MEM: all outputs drop to 0 immediately; after release the FSM is in IDLE and accepts a new RTYPE normally.
